// File: rtl/deskew_ctrl_rx.sv
// deskew_ctrl_rx: rx multi-lane AM deskew controller with lock-full broadcast.
// Optional DESKEW_CTRL_STATS_EN adds a saturating deskew error counter port.
module deskew_ctrl_rx #(
   parameter int LANE_N = 4,
   parameter int MAX_SKEW_BLOCK_N = 27,
   parameter int WIN_CNT_W = $clog2(MAX_SKEW_BLOCK_N)
`ifdef DESKEW_CTRL_STATS_EN
   ,parameter int ERR_CNT_W = 8
`endif
) (
   input  logic              clk,
   input  logic              nreset,
   input  logic [LANE_N-1:0] am_lock_v_i,
   input  logic [LANE_N-1:0] am_v_i,
   input  logic [LANE_N-1:0] skew_zero_i,
   output logic              am_lite_lock_full_v_o,
   output logic              deskew_done_o,
   output logic              skew_err_o
`ifdef DESKEW_CTRL_STATS_EN
   ,output logic [ERR_CNT_W-1:0] err_cnt_o
`endif
);

   typedef enum logic [1:0] {
      IDLE,
      COLLECT,
      CHECK,
      LOCKED
   } state_t;

   localparam logic [WIN_CNT_W-1:0] WIN_MAX =
      WIN_CNT_W'(MAX_SKEW_BLOCK_N - 1);

   state_t            state_q, state_d;
   logic [LANE_N-1:0] seen_q, seen_d;
   logic [WIN_CNT_W-1:0] win_q, win_d;
   logic              full_q, full_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic              all_lock;
   logic [LANE_N-1:0] seen_nx;

   assign all_lock = &am_lock_v_i;
   assign seen_nx  = seen_q | am_v_i;

   // Next-state, skew window tracking and registered output values
   always_comb begin
      state_d = state_q;
      seen_d  = seen_q;
      win_d   = win_q;
      err_d   = 1'b0;
      if (state_q != IDLE && !all_lock) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (all_lock && |am_v_i) begin
                  seen_d  = am_v_i;
                  state_d = (&am_v_i) ? CHECK : COLLECT;
               end
            end
            COLLECT: begin
               seen_d = seen_nx;
               if (win_q != WIN_MAX)
                  win_d = win_q + WIN_CNT_W'(1);
               if (|(am_v_i & seen_q)) begin
                  state_d = IDLE;
                  err_d   = 1'b1;
               end else if (&seen_nx) begin
                  state_d = CHECK;
               end else if (win_q == WIN_MAX) begin
                  state_d = IDLE;
                  err_d   = 1'b1;
               end
            end
            CHECK: begin
               if (|skew_zero_i) begin
                  state_d = LOCKED;
               end else begin
                  state_d = IDLE;
                  err_d   = 1'b1;
               end
            end
            LOCKED: begin
               state_d = LOCKED;
            end
         endcase
      end
      // a fresh collection always starts from an empty mask and window
      if (state_d == IDLE) begin
         win_d = '0;
         if (state_q != IDLE)
            seen_d = '0;
         else if (!(all_lock && |am_v_i))
            seen_d = '0;
      end
      full_d = (state_d == CHECK) || (state_d == LOCKED);
      done_d = (state_d == LOCKED);
   end

   // State and registered outputs, synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!nreset) begin
         state_q <= IDLE;
         seen_q  <= '0;
         win_q   <= '0;
         full_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         seen_q  <= seen_d;
         win_q   <= win_d;
         full_q  <= full_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign am_lite_lock_full_v_o = full_q;
   assign deskew_done_o         = done_q;
   assign skew_err_o            = err_q;

`ifdef DESKEW_CTRL_STATS_EN
   logic [ERR_CNT_W-1:0] cnt_q, cnt_d;

   // Saturating failure count, stepped together with the error pulse
   always_comb begin
      cnt_d = cnt_q;
      if (err_d && cnt_q != '1)
         cnt_d = cnt_q + ERR_CNT_W'(1);
   end

   // Error counter register, cleared only by reset
   always_ff @(posedge clk) begin
      if (!nreset)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign err_cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_deskew_ctrl_rx.sv
// tb_deskew_ctrl_rx: vector table, corner sequences and random model check.
// Build with DESKEW_CTRL_STATS_EN to also check the error counter.
module tb_deskew_ctrl_rx;
   localparam int MAX = 27;

   logic       clk = 1'b0;
   logic       nreset;
   logic [3:0] lock, am, sz_drv, sz;
   logic       full, done, err;
`ifdef DESKEW_CTRL_STATS_EN
   logic [7:0] cnt;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   // lane deskew buffer skew counters (environment)
   int  lane_cnt [4];
   bit  use_lane = 0;
   always @(posedge clk) begin
      for (int l = 0; l < 4; l++) begin
         if (!full) begin
            if (am[l]) lane_cnt[l] <= 0;
            else if (lane_cnt[l] < 1000) lane_cnt[l] <= lane_cnt[l] + 1;
         end
      end
   end

   always_comb begin
      sz = sz_drv;
      if (use_lane)
         for (int l = 0; l < 4; l++) sz[l] = (lane_cnt[l] == 0);
   end

   deskew_ctrl_rx dut (
      .clk                   (clk),
      .nreset                (nreset),
      .am_lock_v_i           (lock),
      .am_v_i                (am),
      .skew_zero_i           (sz),
      .am_lite_lock_full_v_o (full),
      .deskew_done_o         (done),
      .skew_err_o            (err)
`ifdef DESKEW_CTRL_STATS_EN
      ,.err_cnt_o            (cnt)
`endif
   );

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s act=%0d exp=%0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      nreset = 1'b0;
      lock = 4'h0; am = 4'h0; sz_drv = 4'h0;
      step();
      step();
      nreset = 1'b1;
   endtask

   // behavioural model: time-stamped collection of lane AMs
   bit       m_col, m_full, m_done, m_err;
   bit [3:0] m_seen;
   int       m_t0, m_now, m_cnt;

   task automatic model_reset();
      m_col = 0; m_full = 0; m_done = 0; m_err = 0;
      m_seen = 0; m_t0 = 0; m_now = 0; m_cnt = 0;
   endtask

   task automatic model_step(input logic [3:0] lk, a, z);
      m_err = 0;
      if (!m_col && !m_full) begin
         if (&lk && |a) begin
            m_seen = a;
            m_t0 = m_now;
            if (&a) m_full = 1;
            else m_col = 1;
         end
      end else if (!(&lk)) begin
         m_col = 0; m_full = 0; m_done = 0;
      end else if (m_col) begin
         if (|(a & m_seen)) begin
            m_col = 0; m_err = 1;
         end else if (&(m_seen | a)) begin
            m_col = 0; m_full = 1;
         end else if (m_now - m_t0 == MAX) begin
            m_col = 0; m_err = 1;
         end else begin
            m_seen = m_seen | a;
         end
      end else if (!m_done) begin
         if (|z) m_done = 1;
         else begin
            m_full = 0; m_err = 1;
         end
      end
      if (m_err && m_cnt < 255) m_cnt++;
      m_now++;
   endtask

   typedef struct {
      logic [3:0] lk;
      logic [3:0] a;
      logic [3:0] z;
      logic       e_full;
      logic       e_done;
      logic       e_err;
   } vec_t;

   vec_t tbl [15];

   initial begin
      #2_000_000;
      $display("FAIL watchdog act=1 exp=0");
      $fatal(1, "watchdog");
   end

   initial begin
      int ecnt;
      bit bad;
      tbl[0]  = '{4'hF, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0};
      tbl[1]  = '{4'hF, 4'hF, 4'h0, 1'b1, 1'b0, 1'b0};
      tbl[2]  = '{4'hF, 4'h0, 4'hF, 1'b1, 1'b1, 1'b0};
      tbl[3]  = '{4'hF, 4'hF, 4'h0, 1'b1, 1'b1, 1'b0};
      tbl[4]  = '{4'hD, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0};
      tbl[5]  = '{4'hF, 4'hF, 4'h0, 1'b1, 1'b0, 1'b0};
      tbl[6]  = '{4'hF, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1};
      tbl[7]  = '{4'hF, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0};
      tbl[8]  = '{4'hF, 4'h1, 4'h0, 1'b0, 1'b0, 1'b0};
      tbl[9]  = '{4'hF, 4'h1, 4'h0, 1'b0, 1'b0, 1'b1};
      tbl[10] = '{4'hF, 4'h3, 4'h0, 1'b0, 1'b0, 1'b0};
      tbl[11] = '{4'hF, 4'hC, 4'h0, 1'b1, 1'b0, 1'b0};
      tbl[12] = '{4'h7, 4'h0, 4'hF, 1'b0, 1'b0, 1'b0};
      tbl[13] = '{4'h7, 4'hF, 4'hF, 1'b0, 1'b0, 1'b0};
      tbl[14] = '{4'hF, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0};

      do_reset();
      chk("rst_full", full, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
`ifdef DESKEW_CTRL_STATS_EN
      chk("rst_cnt", cnt, 0);
`endif

      // vector table
      ecnt = 0;
      for (int i = 0; i < 15; i++) begin
         lock = tbl[i].lk; am = tbl[i].a; sz_drv = tbl[i].z;
         step();
         chk($sformatf("vec%0d_full", i), full, tbl[i].e_full);
         chk($sformatf("vec%0d_done", i), done, tbl[i].e_done);
         chk($sformatf("vec%0d_err", i), err, tbl[i].e_err);
         ecnt += tbl[i].e_err;
`ifdef DESKEW_CTRL_STATS_EN
         chk($sformatf("vec%0d_cnt", i), cnt, ecnt);
`endif
      end

      // staggered AMs at t, t+2, t+5, t+9
      do_reset();
      use_lane = 1;
      lock = 4'hF; am = 4'h1;
      step();
      for (int c = 1; c <= 9; c++) begin
         chk($sformatf("stag_full_t%0d", c), full, 0);
         am = (c == 2) ? 4'h2 : (c == 5) ? 4'h4 : (c == 9) ? 4'h8 : 4'h0;
         step();
      end
      am = 4'h0;
      chk("stag_full_t10", full, 1);
      chk("stag_done_t10", done, 0);
      step();
      chk("stag_done_t11", done, 1);
      chk("stag_err_t11", err, 0);
      chk("stag_lane0", lane_cnt[0], 9);
      chk("stag_lane1", lane_cnt[1], 7);
      chk("stag_lane2", lane_cnt[2], 4);
      chk("stag_lane3", lane_cnt[3], 0);
      use_lane = 0;
      nreset = 1'b0;
      step();
      chk("midrst_full", full, 0);
      chk("midrst_done", done, 0);
      chk("midrst_err", err, 0);
      nreset = 1'b1;

      // window timeout: lane 3 never shows inside the window
      do_reset();
      lock = 4'hF; am = 4'h7;
      step();
      am = 4'h0;
      bad = 0;
      for (int c = 2; c <= 27; c++) begin
         step();
         if (err || full) bad = 1;
      end
      chk("tmo_early", bad, 0);
      step();
      chk("tmo_err", err, 1);
      chk("tmo_full", full, 0);
      step();
      chk("tmo_pulse_end", err, 0);

      // repeated AM on lane 0
      do_reset();
      lock = 4'hF; am = 4'h1;
      step();
      am = 4'h0;
      step();
      step();
      am = 4'h1;
      step();
      am = 4'h0;
      chk("rep_err", err, 1);
      chk("rep_full", full, 0);
`ifdef DESKEW_CTRL_STATS_EN
      chk("rep_cnt", cnt, 1);

      // saturation after 300 CHECK failures
      do_reset();
      lock = 4'hF; sz_drv = 4'h0;
      for (int k = 0; k < 300; k++) begin
         am = 4'hF;
         step();
         am = 4'h0;
         step();
      end
      chk("sat_cnt", cnt, 255);
`endif

      // randomized run against the behavioural model
      do_reset();
      model_reset();
      for (int c = 0; c < 3000; c++) begin
         int p;
         p = (c < 1500) ? 9 : 39;
         lock = 4'hF;
         if ($urandom_range(0, 39) == 0)
            lock[$urandom_range(0, 3)] = 1'b0;
         for (int l = 0; l < 4; l++)
            am[l] = ($urandom_range(0, p) == 0);
         sz_drv = 4'($urandom_range(0, 15));
         model_step(lock, am, sz_drv);
         step();
         chk("rnd_full", full, m_full);
         chk("rnd_done", done, m_done);
         chk("rnd_err", err, m_err);
`ifdef DESKEW_CTRL_STATS_EN
         chk("rnd_cnt", cnt, m_cnt);
`endif
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
